board_render_ctrl: RTL

- Sequences all pixel writes into the single-port VGA adapter (160x120, 3-bit colour) for the Connect-4 board.
- Serves three requesters over req/ack handshakes: full-board redraw, single-cell update and cursor-column move.
- Reads cell ownership from the board store (index = row*7+col, row 0 = bottom) during a full redraw.
- Renders each cell as a framed square, and the column cursor as a strip above the board.

---
 rtl/board_render_ctrl.sv | 270 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/board_render_ctrl.sv
// board_render_ctrl
// Sequences every pixel write into the single-port 160x120 VGA adapter for the
// Connect-4 board. Three requesters share the plotter through req/ack
// handshakes: a full-board redraw, a single-cell update and a cursor move.
// A redraw walks the 42 cells of the board store (index = row*7+col, row 0 at
// the bottom), draws each as a framed square, and finishes with the cursor strip.
//
// Ports
//   clk, rst              clock, asynchronous active-low reset
//   redraw_req_i/ack_o    full-board redraw request / one-cycle accept
//   cell_req_i/ack_o      single-cell update (cell_col_i, cell_row_i, cell_owner_i)
//   cur_req_i/ack_o       cursor move to cur_col_i
//   brd_addr_o/brd_data_i board store read port (data valid one cycle after addr)
//   vga_x_o/y_o/colour_o  pixel coordinate and colour, held while vga_plot_o=0
//   vga_plot_o            pixel write strobe
//   busy_o                operation in progress
//   done_o                one-cycle pulse at the end of every operation
//   cmd_err_o             one-cycle pulse with done_o for an out-of-range request
//
// Build option
//   ROUND_TOKEN_EN  when defined, the corners of non-empty cell interiors are
//                   painted background so tokens look round; timing unchanged.
module board_render_ctrl #(
    parameter int X0          = 24,
    parameter int Y0          = 20,
    parameter int CELL_LOG2   = 4,
    parameter int MARK_H      = 4,
    parameter int AUTO_REDRAW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       redraw_req_i,
    output logic       redraw_ack_o,
    input  logic       cell_req_i,
    input  logic [2:0] cell_col_i,
    input  logic [2:0] cell_row_i,
    input  logic [1:0] cell_owner_i,
    output logic       cell_ack_o,
    input  logic       cur_req_i,
    input  logic [2:0] cur_col_i,
    output logic       cur_ack_o,
    output logic [5:0] brd_addr_o,
    input  logic [1:0] brd_data_i,
    output logic [7:0] vga_x_o,
    output logic [6:0] vga_y_o,
    output logic [2:0] vga_colour_o,
    output logic       vga_plot_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       cmd_err_o
);

    localparam int SIDE       = 1 << CELL_LOG2;
    localparam int CW         = 2 * CELL_LOG2;
    localparam int CELL_LAST  = SIDE * SIDE - 1;
    localparam int STRIP_LAST = MARK_H * SIDE - 1;
    localparam int STRIP_Y    = Y0 - MARK_H - 2;
    localparam int NCELLS     = 42;

    typedef enum logic [2:0] {
        IDLE, RD_ADDR, RD_WAIT, FILL, CUR_ERASE, CUR_DRAW, FINISH
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;       // pixel counter, px in the low bits
    logic [2:0]      col_q;       // column being drawn (cell or cursor strip)
    logic [2:0]      row_q;
    logic [1:0]      owner_q;
    logic [2:0]      cursor_q;
    logic            redraw_q;    // FILL belongs to a full redraw
    logic            err_q;
    logic [5:0]      brd_addr_q;
    logic [7:0]      vga_x_q;
    logic [6:0]      vga_y_q;
    logic [2:0]      vga_colour_q;
    logic            vga_plot_q, busy_q, done_q, cmd_err_q;
    logic            redraw_ack_q, cell_ack_q, cur_ack_q;

    logic [CELL_LOG2-1:0] px, py;
    logic [7:0]           pix_x_d;
    logic [6:0]           pix_y_d;
    logic [2:0]           pix_c_d;

    assign px = cnt_q[CELL_LOG2-1:0];
    assign py = cnt_q[CW-1:CELL_LOG2];

    function automatic logic [2:0] owner_colour(input logic [1:0] owner);
        case (owner)
            2'b00:   owner_colour = 3'b000;
            2'b01:   owner_colour = 3'b100;
            2'b10:   owner_colour = 3'b110;
            default: owner_colour = 3'b111;
        endcase
    endfunction

    function automatic logic on_border(input logic [CELL_LOG2-1:0] x, input logic [CELL_LOG2-1:0] y);
        on_border = (x == '0) || (x == '1) || (y == '0) || (y == '1);
    endfunction

`ifdef ROUND_TOKEN_EN
    // Distance-to-edge sum of an interior pixel; small sums are the four corners.
    function automatic logic in_corner(input logic [CELL_LOG2-1:0] x, input logic [CELL_LOG2-1:0] y);
        int dx, dy;
        dx = (int'(x) - 1 < SIDE - 2 - int'(x)) ? int'(x) - 1 : SIDE - 2 - int'(x);
        dy = (int'(y) - 1 < SIDE - 2 - int'(y)) ? int'(y) - 1 : SIDE - 2 - int'(y);
        in_corner = (dx + dy) < 3;
    endfunction
`endif

    // Pixel about to be plotted; row 0 is the bottom row of the board.
    always_comb begin
        pix_x_d = 8'(X0 + (int'(col_q) << CELL_LOG2) + int'(px));
        if (state_q == FILL) begin
            pix_y_d = 7'(Y0 + ((5 - int'(row_q)) << CELL_LOG2) + int'(py));
            if (on_border(px, py))
                pix_c_d = 3'b001;
`ifdef ROUND_TOKEN_EN
            else if (owner_q != 2'b00 && in_corner(px, py))
                pix_c_d = 3'b000;
`endif
            else
                pix_c_d = owner_colour(owner_q);
        end else begin
            pix_y_d = 7'(STRIP_Y + int'(py));
            pix_c_d = (state_q == CUR_DRAW) ? 3'b111 : 3'b000;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= (AUTO_REDRAW != 0) ? RD_ADDR : IDLE;
            redraw_q     <= (AUTO_REDRAW != 0);
            cnt_q        <= '0;
            col_q        <= '0;
            row_q        <= '0;
            owner_q      <= '0;
            cursor_q     <= '0;
            err_q        <= 1'b0;
            brd_addr_q   <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            redraw_ack_q <= 1'b0;
            cell_ack_q   <= 1'b0;
            cur_ack_q    <= 1'b0;
        end else begin
            redraw_ack_q <= 1'b0;
            cell_ack_q   <= 1'b0;
            cur_ack_q    <= 1'b0;
            done_q       <= 1'b0;
            cmd_err_q    <= 1'b0;
            vga_plot_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (redraw_req_i) begin
                        redraw_ack_q <= 1'b1;
                        redraw_q     <= 1'b1;
                        brd_addr_q   <= '0;
                        col_q        <= '0;
                        row_q        <= '0;
                        state_q      <= RD_ADDR;
                    end else if (cell_req_i) begin
                        cell_ack_q <= 1'b1;
                        if (cell_col_i > 3'd6 || cell_row_i > 3'd5) begin
                            err_q   <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            col_q    <= cell_col_i;
                            row_q    <= cell_row_i;
                            owner_q  <= cell_owner_i;
                            redraw_q <= 1'b0;
                            cnt_q    <= '0;
                            state_q  <= FILL;
                        end
                    end else if (cur_req_i) begin
                        cur_ack_q <= 1'b1;
                        if (cur_col_i > 3'd6) begin
                            err_q   <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            // Erase uses the old column, draw the new one.
                            col_q    <= cursor_q;
                            cursor_q <= cur_col_i;
                            cnt_q    <= '0;
                            state_q  <= CUR_ERASE;
                        end
                    end
                end
                RD_ADDR: begin
                    busy_q  <= 1'b1;
                    state_q <= RD_WAIT;
                end
                RD_WAIT: begin
                    busy_q  <= 1'b1;
                    owner_q <= brd_data_i;
                    cnt_q   <= '0;
                    state_q <= FILL;
                end
                FILL: begin
                    busy_q       <= 1'b1;
                    vga_plot_q   <= 1'b1;
                    vga_x_q      <= pix_x_d;
                    vga_y_q      <= pix_y_d;
                    vga_colour_q <= pix_c_d;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == CW'(CELL_LAST)) begin
                        if (!redraw_q) begin
                            state_q <= FINISH;
                        end else if (brd_addr_q == 6'(NCELLS - 1)) begin
                            col_q   <= cursor_q;
                            cnt_q   <= '0;
                            state_q <= CUR_DRAW;
                        end else begin
                            brd_addr_q <= brd_addr_q + 1'b1;
                            if (col_q == 3'd6) begin
                                col_q <= '0;
                                row_q <= row_q + 1'b1;
                            end else begin
                                col_q <= col_q + 1'b1;
                            end
                            state_q <= RD_ADDR;
                        end
                    end
                end
                CUR_ERASE, CUR_DRAW: begin
                    busy_q       <= 1'b1;
                    vga_plot_q   <= 1'b1;
                    vga_x_q      <= pix_x_d;
                    vga_y_q      <= pix_y_d;
                    vga_colour_q <= pix_c_d;
                    cnt_q        <= cnt_q + 1'b1;
                    if (cnt_q == CW'(STRIP_LAST)) begin
                        cnt_q <= '0;
                        if (state_q == CUR_ERASE) begin
                            col_q   <= cursor_q;
                            state_q <= CUR_DRAW;
                        end else begin
                            state_q <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    done_q    <= 1'b1;
                    cmd_err_q <= err_q;
                    err_q     <= 1'b0;
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign redraw_ack_o = redraw_ack_q;
    assign cell_ack_o   = cell_ack_q;
    assign cur_ack_o    = cur_ack_q;
    assign brd_addr_o   = brd_addr_q;
    assign vga_x_o      = vga_x_q;
    assign vga_y_o      = vga_y_q;
    assign vga_colour_o = vga_colour_q;
    assign vga_plot_o   = vga_plot_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign cmd_err_o    = cmd_err_q;

endmodule
